// File: rtl/bit_entry_ctrl.sv
// -----------------------------------------------------------------------------
// bit_entry_ctrl
//   Front end of the LED shift stage. Turns three raw, bouncing, active-low
//   pushbuttons into clean single-cycle events on one clock:
//     - shift + n : enter a '0' (key0) or '1' (key1) into the display
//     - undo      : step the downstream history back by one entry
//   It also tracks how many bits are on display and how many undo steps are
//   still available.
//
//   Latency: a clean raw falling edge produces its event pulse exactly
//   DEB_CYCLES+3 cycles later (2 synchroniser stages + DEB_CYCLES of stable
//   debounce + 1 arbitration register).
//
//   Build option: define UNDO_EN to build the undo path. When it is left
//   undefined, keyu_raw is ignored, undo and undo_avail stay 0, and bit_count
//   only ever counts up.
//
// Ports
//   clk         in   1  system clock, all logic on posedge
//   reset       in   1  asynchronous, active-low reset
//   key0_raw    in   1  raw pushbutton for bit '0' (active-low, async)
//   key1_raw    in   1  raw pushbutton for bit '1' (active-low, async)
//   keyu_raw    in   1  raw pushbutton for undo    (active-low, async)
//   n           out  1  data bit, valid while shift=1, holds otherwise
//   shift       out  1  one-cycle pulse: downstream shifts n in
//   undo        out  1  one-cycle pulse: downstream restores history
//   conflict    out  1  one-cycle pulse: key0/key1 pressed in the same cycle
//   bit_count   out  5  bits on display, saturates at MAX_BITS
//   undo_avail  out  3  undo steps available, saturates at UNDO_DEPTH
// -----------------------------------------------------------------------------

// Per-key input path: 2-FF synchroniser, debouncer and registered press
// detector. press is a one-cycle pulse on the debounced 1->0 transition.
module bit_entry_key #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic press
);
    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic [CNT_W-1:0] cnt;

    // NOTE: every flop here, including the synchronisers, is reset so that a
    // reset mid-debounce leaves no stale partial count or pending pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            deb   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, which is what makes sync1->sync2
            // a true two-stage chain.
            sync1 <= key_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != deb) begin
                if (cnt == CNT_MAX) begin
                    // Level has differed for DEB_CYCLES consecutive cycles.
                    deb   <= sync2;
                    cnt   <= '0;
                    press <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module bit_entry_ctrl #(
    parameter int DEB_CYCLES = 1000,
    parameter int MAX_BITS   = 18,
    parameter int UNDO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key0_raw,
    input  logic       key1_raw,
    input  logic       keyu_raw,
    output logic       n,
    output logic       shift,
    output logic       undo,
    output logic       conflict,
    output logic [4:0] bit_count,
    output logic [2:0] undo_avail
);
    localparam logic [4:0] MAX_C   = 5'(MAX_BITS);
    localparam logic [2:0] DEPTH_C = 3'(UNDO_DEPTH);

    logic press_0;
    logic press_1;
    logic press_u;

    bit_entry_key #(.DEB_CYCLES(DEB_CYCLES)) u_key0 (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key0_raw),
        .press   (press_0)
    );

    bit_entry_key #(.DEB_CYCLES(DEB_CYCLES)) u_key1 (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key1_raw),
        .press   (press_1)
    );

`ifdef UNDO_EN
    localparam bit UNDO_ON = 1'b1;

    bit_entry_key #(.DEB_CYCLES(DEB_CYCLES)) u_keyu (
        .clk     (clk),
        .reset   (reset),
        .key_raw (keyu_raw),
        .press   (press_u)
    );
`else
    localparam bit UNDO_ON = 1'b0;

    // Undo key is not built; the raw pin is deliberately left unconnected.
    logic keyu_unused;
    assign keyu_unused = keyu_raw;
    assign press_u     = 1'b0;
`endif

    logic       n_nxt;
    logic       shift_nxt;
    logic       undo_nxt;
    logic       conflict_nxt;
    logic [4:0] bit_count_nxt;
    logic [2:0] undo_avail_nxt;

    // Arbitration: undo press beats any bit press; simultaneous key0/key1
    // presses cancel each other and raise conflict instead.
    always_comb begin
        // NOTE: all outputs get a default first so no path can infer a latch.
        n_nxt          = n;
        shift_nxt      = 1'b0;
        undo_nxt       = 1'b0;
        conflict_nxt   = 1'b0;
        bit_count_nxt  = bit_count;
        undo_avail_nxt = undo_avail;

        if (press_u) begin
            // With no history left the press is swallowed silently.
            if (undo_avail != 3'd0) begin
                undo_nxt       = 1'b1;
                undo_avail_nxt = undo_avail - 3'd1;
                if (bit_count != 5'd0) begin
                    bit_count_nxt = bit_count - 5'd1;
                end
            end
        end else if (press_0 && press_1) begin
            conflict_nxt = 1'b1;
        end else if (press_0 || press_1) begin
            n_nxt     = press_1;
            shift_nxt = 1'b1;
            // Shifts past a full display still pulse; only the count saturates.
            if (bit_count < MAX_C) begin
                bit_count_nxt = bit_count + 5'd1;
            end
            if (UNDO_ON && (undo_avail < DEPTH_C)) begin
                undo_avail_nxt = undo_avail + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n          <= 1'b0;
            shift      <= 1'b0;
            undo       <= 1'b0;
            conflict   <= 1'b0;
            bit_count  <= 5'd0;
            undo_avail <= 3'd0;
        end else begin
            n          <= n_nxt;
            shift      <= shift_nxt;
            undo       <= undo_nxt;
            conflict   <= conflict_nxt;
            bit_count  <= bit_count_nxt;
            undo_avail <= undo_avail_nxt;
        end
    end
endmodule

// File: tb/tb_bit_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bit_entry_ctrl
//   Directed bench for bit_entry_ctrl with DEB_CYCLES=4, MAX_BITS=18,
//   UNDO_DEPTH=4. Inputs change 1 time unit after a rising edge; outputs are
//   observed on the falling edge. "Cycle 0" is the cycle in which a key is
//   first driven low, so an event is expected in cycle 7. Expectations for the
//   undo path follow the UNDO_EN build option.
// -----------------------------------------------------------------------------
module tb_bit_entry_ctrl;
    localparam int DEB  = 4;
    localparam int MAXB = 18;
    localparam int UD   = 4;

`ifdef UNDO_EN
    localparam bit UNDO_ON = 1'b1;
`else
    localparam bit UNDO_ON = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       key0_raw = 1'b1;
    logic       key1_raw = 1'b1;
    logic       keyu_raw = 1'b1;
    logic       n;
    logic       shift;
    logic       undo;
    logic       conflict;
    logic [4:0] bit_count;
    logic [2:0] undo_avail;

    int n_checks = 0;
    int n_fail   = 0;

    bit_entry_ctrl #(
        .DEB_CYCLES (DEB),
        .MAX_BITS   (MAXB),
        .UNDO_DEPTH (UD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key0_raw   (key0_raw),
        .key1_raw   (key1_raw),
        .keyu_raw   (keyu_raw),
        .n          (n),
        .shift      (shift),
        .undo       (undo),
        .conflict   (conflict),
        .bit_count  (bit_count),
        .undo_avail (undo_avail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int n_shift  = 0;
    int n_undo   = 0;
    int n_conf   = 0;
    int shift_at = -1;
    always @(negedge clk) begin
        if (shift) begin
            n_shift  = n_shift + 1;
            shift_at = cyc;
        end
        if (undo)     n_undo = n_undo + 1;
        if (conflict) n_conf = n_conf + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_shift  = 0;
        n_undo   = 0;
        n_conf   = 0;
        shift_at = -1;
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_key(input int which, input logic lvl);
        case (which)
            0:       key0_raw = lvl;
            1:       key1_raw = lvl;
            default: keyu_raw = lvl;
        endcase
    endtask

    task automatic press(input int which, input int low, input int high);
        set_key(which, 1'b0);
        tick(low);
        set_key(which, 1'b1);
        tick(high);
    endtask

    int t0;

    initial begin
        // Reset state
        tick(3);
        check("rst_n",         32'(n),          32'd0);
        check("rst_shift",     32'(shift),      32'd0);
        check("rst_undo",      32'(undo),       32'd0);
        check("rst_conflict",  32'(conflict),   32'd0);
        check("rst_bit_count", 32'(bit_count),  32'd0);
        check("rst_undo_av",   32'(undo_avail), 32'd0);
        reset = 1'b1;
        tick(3);

        // Held key1: one shift in cycle 7, no auto-repeat
        clear_mon();
        t0 = cyc;
        key1_raw = 1'b0;
        tick(20);
        check("hold_shift_cycle", 32'(shift_at - t0), 32'd7);
        check("hold_shift_count", 32'(n_shift),       32'd1);
        check("hold_n",           32'(n),             32'd1);
        check("hold_bit_count",   32'(bit_count),     32'd1);
        check("hold_undo_av",     32'(undo_avail),    UNDO_ON ? 32'd1 : 32'd0);
        key1_raw = 1'b1;
        tick(10);
        check("release_no_shift", 32'(n_shift), 32'd1);

        // 3-cycle glitch on key0: filtered
        clear_mon();
        press(0, 3, 15);
        check("glitch_shift_count", 32'(n_shift),   32'd0);
        check("glitch_bit_count",   32'(bit_count), 32'd1);

        // Bounce key0 every cycle, then hold low: exactly one shift of '0'
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            key0_raw = (i % 2 == 1);
            tick(1);
        end
        key0_raw = 1'b0;
        tick(15);
        check("bounce_shift_count", 32'(n_shift),   32'd1);
        check("bounce_n",           32'(n),         32'd0);
        check("bounce_bit_count",   32'(bit_count), 32'd2);
        key0_raw = 1'b1;
        tick(10);

        // key0 and key1 together: conflict once, nothing shifted
        clear_mon();
        key0_raw = 1'b0;
        key1_raw = 1'b0;
        tick(15);
        key0_raw = 1'b1;
        key1_raw = 1'b1;
        tick(10);
        check("conf_count",       32'(n_conf),    32'd1);
        check("conf_shift_count", 32'(n_shift),   32'd0);
        check("conf_bit_count",   32'(bit_count), 32'd2);

        // 20 presses: bit_count saturates at MAX_BITS, undo_avail at depth
        clear_mon();
        for (int i = 0; i < 20; i++) press(1, 8, 8);
        check("fill_shift_count", 32'(n_shift),    32'd20);
        check("fill_bit_count",   32'(bit_count),  32'd18);
        check("fill_undo_av",     32'(undo_avail), UNDO_ON ? 32'd4 : 32'd0);

        // 6 undo presses: only 4 take effect (none without the undo path)
        clear_mon();
        for (int i = 0; i < 6; i++) press(2, 8, 8);
        check("undo_count",      32'(n_undo),     UNDO_ON ? 32'd4 : 32'd0);
        check("undo_shift",      32'(n_shift),    32'd0);
        check("undo_bit_count",  32'(bit_count),  UNDO_ON ? 32'd14 : 32'd18);
        check("undo_undo_av",    32'(undo_avail), 32'd0);

        // Reset mid-debounce with key1 held through release
        key1_raw = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        check("mid_rst_shift",     32'(shift),      32'd0);
        check("mid_rst_n",         32'(n),          32'd0);
        check("mid_rst_bit_count", 32'(bit_count),  32'd0);
        check("mid_rst_undo_av",   32'(undo_avail), 32'd0);
        clear_mon();
        reset = 1'b1;
        t0 = cyc;
        tick(12);
        check("post_rst_shift_cycle", 32'(shift_at - t0), 32'd7);
        check("post_rst_shift_count", 32'(n_shift),       32'd1);
        check("post_rst_n",           32'(n),             32'd1);
        check("post_rst_bit_count",   32'(bit_count),     32'd1);
        check("post_rst_undo_av",     32'(undo_avail),    UNDO_ON ? 32'd1 : 32'd0);
        key1_raw = 1'b1;
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
